sprite_ram_arbiter: RTL
=======================

# sprite_ram_arbiter

Shares one sprite RAM (single read port, single write port, 1-cycle registered read, 4-bit palette index per entry) between three masters: the VGA pixel fetch path, the collision checker and the sprite loader. The pixel path has absolute read priority, the collision checker takes idle read slots, and the loader may write only during vertical blanking. Read data is tagged and returned to the master that issued the read. It sits between the sprite draw logic and the RAM instance in the top-level.

## Interface
- ADDR_W, 19, address width of all address ports
- DATA_W, 4, palette index width
- DEPTH, 27750, number of valid RAM entries; addresses ≥ DEPTH are out of range
- STARVE_MAX, 1023, denied-cycle count at which col_starved is raised

- Clk  in  1  single clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- vblank  in  1  high during vertical blanking; write window
- pix_req  in  1  pixel read request, valid for one cycle
- pix_addr  in  ADDR_W  pixel read address
- pix_valid  out  1  pixel read data valid
- pix_data  out  DATA_W  pixel read data
- col_req  in  1  collision read request, held until col_gnt
- col_addr  in  ADDR_W  collision read address, stable while col_req
- col_gnt  out  1  collision request accepted this cycle
- col_valid  out  1  collision read data valid
- col_data  out  DATA_W  collision read data
- col_starved  out  1  sticky starvation flag
- ld_req  in  1  loader write request, held until ld_gnt
- ld_addr  in  ADDR_W  write address
- ld_data  in  DATA_W  write data
- ld_gnt  out  1  write accepted this cycle
- addr_err  out  1  sticky out-of-range access flag
- ram_read_address  out  ADDR_W  to RAM
- ram_write_address  out  ADDR_W  to RAM
- ram_data_In  out  DATA_W  to RAM
- ram_we  out  1  to RAM
- ram_data_Out  in  DATA_W  from RAM

## Operation
- Read arbitration (combinational, per cycle): pix_req wins unconditionally; col_gnt = col_req & ~pix_req. ram_read_address = granted address; pix_addr when neither is granted.
- Tag register: 2-bit owner {NONE, PIX, COL} captured each cycle from the grant. Out-of-range reads are granted but tagged as "zero return"; the RAM read port is not used for them.
- Return: pix_valid/col_valid asserted one cycle after grant per the tag; data = ram_data_Out, or 0 for out-of-range. Data outputs are 0 when their valid is low.
- Writes: ld_gnt = ld_req & vblank & Reset_n. ram_we = ld_gnt & (ld_addr < DEPTH). Out-of-range writes are granted and dropped. ram_write_address/ram_data_In mirror ld_addr/ld_data.
- addr_err: set on any granted out-of-range read or write; cleared only by reset.
- Starvation counter (STARVE_W = clog2(STARVE_MAX+1)): increments on col_req & ~col_gnt, saturates at STARVE_MAX, clears on col_gnt. col_starved sets when count reaches STARVE_MAX and clears on the next col_gnt.
- Same-cycle write and read to one address: the RAM returns the old value unless the hazard stall is compiled in (see Configuration).

## Timing
- Reset values: tag NONE, pix_valid 0, col_valid 0, pix_data 0, col_data 0, col_starved 0, addr_err 0, starvation count 0. ram_we and ld_gnt are forced 0 while Reset_n is low.
- Read latency: grant in cycle N, valid and data in cycle N+1. Back-to-back reads sustain one per cycle.
- Write: accepted in the cycle ld_gnt is high; visible to reads issued from N+1.
- vblank falling while ld_req is held: ld_gnt drops in the same cycle, and the request stays pending.
- Reset asserted mid-read: the in-flight tag is discarded and no valid is produced after release.

## Configuration
- SPRITE_ARB_WRHAZARD_EN defined: ld_gnt is additionally deasserted when ram_we would fire with ld_addr equal to the granted in-range read address. The write retries the next cycle, and the read returns the pre-write value.
- Undefined: there is no stall. The write proceeds, and the colliding read returns the old value.

## Test plan
- Reset: Reset_n=0 with all reqs=1 -> all outputs 0, ram_we=0. Release -> first pix_valid appears one cycle after the first pix_req.
- Priority: pix_req and col_req both high for 3 cycles, then pix_req low -> col_gnt only in cycle 4, col_valid in cycle 5 with col_data = mem[col_addr].
- Starvation with STARVE_MAX=4: col_req held and pix_req constantly high -> col_starved=1 after the 4th denied cycle. Drop pix_req -> col_gnt=1, and col_starved=0 the next cycle.
- Write window: ld_req with addr 0x100, data 0xA, vblank=0 -> no ld_gnt. Raise vblank -> ld_gnt and ram_we. A pix read of 0x100 the next cycle returns 0xA.
- Out-of-range: pix_addr=27750 -> pix_valid=1, pix_data=0, addr_err=1. ld_addr=30000 -> ld_gnt=1, ram_we=0.
- Hazard: ld write to 0x20 with value 0x5 and pix read of 0x20 in the same cycle (old 0x3). With the macro: ld_gnt=0 that cycle, read returns 0x3, write completes the next cycle. Without the macro: ld_gnt=1, read returns 0x3.

Source files
------------

// File: rtl/sprite_ram_arbiter.sv
// sprite_ram_arbiter: shares one sprite RAM (1R/1W, registered read) between
// the pixel fetch path (absolute read priority), the collision checker (idle
// read slots) and the sprite loader (writes only during vblank).
// Optional: define SPRITE_ARB_WRHAZARD_EN to hold off a loader write that
// targets the address being read in the same cycle.
//
// Handshake rules: pix_req is a one-cycle strobe and is always served.
// col_req/ld_req are held with their address/data stable until the matching
// *_gnt is seen high in a cycle; the transfer happens in that cycle. Read data
// comes back exactly one cycle after the grant, qualified by *_valid.
module sprite_ram_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 4,
    parameter int DEPTH      = 27750,
    parameter int STARVE_MAX = 1023
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vblank,
    input  logic              pix_req,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    input  logic              col_req,
    input  logic [ADDR_W-1:0] col_addr,
    output logic              col_gnt,
    output logic              col_valid,
    output logic [DATA_W-1:0] col_data,
    output logic              col_starved,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_gnt,
    output logic              addr_err,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_data_In,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_Out
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0]   DEPTH_A    = ADDR_W'(DEPTH);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_PIX  = 2'd1;
    localparam logic [1:0] TAG_COL  = 2'd2;

    logic [1:0]          tag_q, tag_d;
    logic                zero_q, zero_d;
    logic                addr_err_q, addr_err_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                starved_q, starved_d;

    logic              rd_granted;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_oor;
    logic              ld_oor;
    logic              wr_hazard;

    // Read arbitration: pixel path always wins, collision takes idle slots.
    always_comb begin
        col_gnt    = col_req & ~pix_req;
        rd_granted = pix_req | col_gnt;
        rd_addr    = col_gnt ? col_addr : pix_addr;
        rd_oor     = rd_addr >= DEPTH_A;
        ld_oor     = ld_addr >= DEPTH_A;
    end

    // Write acceptance, optionally stalled by a same-address read.
    always_comb begin
`ifdef SPRITE_ARB_WRHAZARD_EN
        wr_hazard = ld_req & vblank & ~ld_oor & rd_granted & ~rd_oor &
                    (ld_addr == rd_addr);
`else
        wr_hazard = 1'b0;
`endif
        ld_gnt            = ld_req & vblank & Reset_n & ~wr_hazard;
        ram_we            = ld_gnt & ~ld_oor;
        ram_write_address = ld_addr;
        ram_data_In       = ld_data;
        ram_read_address  = rd_addr;
    end

    // Next-state for tag, sticky error and starvation tracking.
    always_comb begin
        tag_d = TAG_NONE;
        if (pix_req) begin
            tag_d = TAG_PIX;
        end else if (col_gnt) begin
            tag_d = TAG_COL;
        end
        zero_d     = rd_granted & rd_oor;
        addr_err_d = addr_err_q | (rd_granted & rd_oor) | (ld_gnt & ld_oor);

        starve_cnt_d = starve_cnt_q;
        if (col_gnt) begin
            starve_cnt_d = '0;
        end else if (col_req && starve_cnt_q < STARVE_TOP) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        starved_d = col_gnt ? 1'b0 : (starved_q | (starve_cnt_d == STARVE_TOP));
    end

    // State registers; reset discards any in-flight read tag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tag_q        <= TAG_NONE;
            zero_q       <= 1'b0;
            addr_err_q   <= 1'b0;
            starve_cnt_q <= '0;
            starved_q    <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            zero_q       <= zero_d;
            addr_err_q   <= addr_err_d;
            starve_cnt_q <= starve_cnt_d;
            starved_q    <= starved_d;
        end
    end

    // Return path: route RAM data to the owner, zero for out-of-range reads.
    always_comb begin
        pix_valid   = (tag_q == TAG_PIX);
        col_valid   = (tag_q == TAG_COL);
        pix_data    = (pix_valid && !zero_q) ? ram_data_Out : '0;
        col_data    = (col_valid && !zero_q) ? ram_data_Out : '0;
        col_starved = starved_q;
        addr_err    = addr_err_q;
    end

endmodule
